// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register: FSM states and occupancy encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_st_t;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_MAX = 2'd2;

    function automatic occ_t state_occ(input stage_st_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_TWO:  return OCC_MAX;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One register slot of the elastic stage: payload, control bits, tag and valid.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [TAG_W-1:0]  o_tag
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic [TAG_W-1:0]  r_tag;

    // Clear keeps data/tag so a bubble still shows the last payload, but zeroes ctrl.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_tag   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;
    assign o_tag   = r_tag;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and occupancy reporting.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        occupancy
);

    stage_st_t         r_state;
    stage_st_t         w_state_d;
    logic              r_in_ready;
    logic              w_accept;
    logic              w_take;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [TAG_W-1:0]  w_skid_tag;
    logic [DATA_W-1:0] w_main_data_in;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [TAG_W-1:0]  w_main_tag_in;

    assign w_accept = in_valid && in_ready;
    assign w_take   = out_valid && out_ready;

    always_comb begin
        w_state_d    = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush) begin
            w_state_d    = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_take) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        // Only reachable with a skid entry: without one, accept implies take.
                        w_skid_load = 1'b1;
                        w_state_d   = ST_TWO;
                    end else if (w_take) begin
                        w_main_clear = 1'b1;
                        w_state_d    = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_take) begin
                        w_main_load  = 1'b1;
                        w_skid_clear = 1'b1;
                        w_state_d    = ST_ONE;
                    end
                end
                default: w_state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d != ST_TWO);
        end
    end

    // A valid skid entry always refills main before any new beat.
    assign w_main_data_in = w_skid_valid ? w_skid_data : in_data;
    assign w_main_ctrl_in = w_skid_valid ? w_skid_ctrl : in_ctrl;
    assign w_main_tag_in  = w_skid_valid ? w_skid_tag  : in_tag;

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .TAG_W  (TAG_W)
    ) u_main (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_data_in),
        .i_ctrl  (w_main_ctrl_in),
        .i_tag   (w_main_tag_in),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_ctrl  (out_ctrl),
        .o_tag   (out_tag)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W),
            .TAG_W  (TAG_W)
        ) u_skid (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_data  (in_data),
            .i_ctrl  (in_ctrl),
            .i_tag   (in_tag),
            .o_valid (w_skid_valid),
            .o_data  (w_skid_data),
            .o_ctrl  (w_skid_ctrl),
            .o_tag   (w_skid_tag)
        );
        assign in_ready = r_in_ready;
    end else begin : g_no_skid
        assign w_skid_valid = 1'b0;
        assign w_skid_data  = '0;
        assign w_skid_ctrl  = '0;
        assign w_skid_tag   = '0;
        assign in_ready     = !out_valid || out_ready;
    end

    assign occupancy = state_occ(r_state);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench: SKID=1 and SKID=0 instances against a queue-based reference model.
module tb_pipe_stage_elastic;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  c;
        logic [4:0]  t;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        fl    [2];
    logic        iv    [2];
    logic        ir    [2];
    logic        ov    [2];
    logic        ordy  [2];
    logic [31:0] idata [2];
    logic [31:0] odata [2];
    logic [1:0]  ictrl [2];
    logic [1:0]  octrl [2];
    logic [4:0]  itag  [2];
    logic [4:0]  otag  [2];
    logic [1:0]  occ   [2];

    beat_t sb [2][$];
    beat_t last [2];
    bit    exp_rdy [2];
    bit    mon_en;
    int    n_chk;
    int    n_pass;
    int    bias;

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(2), .TAG_W(5), .SKID(1)) u_dut_skid (
        .CLK (clk), .RST (rst), .flush (fl[0]),
        .in_valid (iv[0]), .in_ready (ir[0]), .in_data (idata[0]), .in_ctrl (ictrl[0]),
        .in_tag (itag[0]), .out_valid (ov[0]), .out_ready (ordy[0]), .out_data (odata[0]),
        .out_ctrl (octrl[0]), .out_tag (otag[0]), .occupancy (occ[0])
    );

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(2), .TAG_W(5), .SKID(0)) u_dut_noskid (
        .CLK (clk), .RST (rst), .flush (fl[1]),
        .in_valid (iv[1]), .in_ready (ir[1]), .in_data (idata[1]), .in_ctrl (ictrl[1]),
        .in_tag (itag[1]), .out_valid (ov[1]), .out_ready (ordy[1]), .out_data (odata[1]),
        .out_ctrl (octrl[1]), .out_tag (otag[1]), .occupancy (occ[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, int k, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, got, exp, $time);
    endfunction

    // Monitor: outputs against the model, then apply the take/flush of the coming edge.
    always @(negedge clk) begin
        int    sz;
        bit    rdy;
        beat_t hd;
        if (mon_en && !rst) begin
            for (int k = 0; k < 2; k++) begin
                sz  = sb[k].size();
                rdy = (k == 0) ? (sz < 2) : (sz == 0 || ordy[k]);
                exp_rdy[k] = rdy;
                chk("occupancy", k, 64'(occ[k]), 64'(sz));
                chk("out_valid", k, 64'(ov[k]), 64'(sz > 0));
                chk("in_ready", k, 64'(ir[k]), 64'(rdy));
                if (sz > 0) begin
                    hd = sb[k][0];
                    last[k] = hd;
                    chk("out_data", k, 64'(odata[k]), 64'(hd.d));
                    chk("out_ctrl", k, 64'(octrl[k]), 64'(hd.c));
                    chk("out_tag", k, 64'(otag[k]), 64'(hd.t));
                end else begin
                    chk("bubble_ctrl", k, 64'(octrl[k]), 64'd0);
                    chk("bubble_data", k, 64'(odata[k]), 64'(last[k].d));
                    chk("bubble_tag", k, 64'(otag[k]), 64'(last[k].t));
                end
                if (sz > 0 && ordy[k]) void'(sb[k].pop_front());
                if (fl[k]) sb[k].delete();
            end
        end
    end

    // Stimulus side: record every beat that the handshake accepts this cycle.
    always @(negedge clk) begin
        beat_t b;
        #1;
        if (mon_en && !rst) begin
            for (int k = 0; k < 2; k++) begin
                if (iv[k] && exp_rdy[k] && !fl[k]) begin
                    b = {idata[k], ictrl[k], itag[k]};
                    sb[k].push_back(b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int k, input bit v, input logic [31:0] d, input logic [1:0] c,
                          input logic [4:0] t);
        iv[k]    = v;
        idata[k] = d;
        ictrl[k] = c;
        itag[k]  = t;
        fl[k]    = 1'b0;
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    task automatic do_reset();
        mon_en = 1'b0;
        rst    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            fl[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, 64'(ov[k]), 64'd0);
            chk("rst_out_ctrl", k, 64'(octrl[k]), 64'd0);
            chk("rst_out_data", k, 64'(odata[k]), 64'd0);
            chk("rst_out_tag", k, 64'(otag[k]), 64'd0);
            chk("rst_occupancy", k, 64'(occ[k]), 64'd0);
            chk("rst_in_ready", k, 64'(ir[k]), 64'd1);
            sb[k].delete();
            last[k] = '0;
        end
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_in(k, 1'b0, '0, '0, '0);
            ordy[k]    = 1'b1;
            exp_rdy[k] = 1'b1;
            last[k]    = '0;
        end
        step();
        do_reset();

        // Reset while a beat is held.
        ordy[0] = 1'b0;
        set_in(0, 1'b1, 32'hDEADBEEF, 2'b11, 5'd7);
        step();
        set_in(0, 1'b0, '0, '0, '0);
        chk("held_before_rst", 0, 64'(odata[0]), 64'hDEADBEEF);
        do_reset();

        // Streaming on both instances.
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_in(0, 1'b1, 32'(i), 2'(i), 5'(i));
            set_in(1, 1'b1, 32'(i), 2'(i), 5'(i));
            step();
        end
        set_in(0, 1'b0, '0, '0, '0);
        set_in(1, 1'b0, '0, '0, '0);
        step();
        step();

        // Backpressure into the skid entry.
        set_in(0, 1'b1, 32'hA, 2'd1, 5'd1);
        step();
        ordy[0] = 1'b0;
        set_in(0, 1'b1, 32'hB, 2'd2, 5'd2);
        step();
        set_in(0, 1'b0, '0, '0, '0);
        chk("bp_in_ready", 0, 64'(ir[0]), 64'd0);
        chk("bp_occupancy", 0, 64'(occ[0]), 64'd2);
        step();
        ordy[0] = 1'b1;
        step();
        chk("bp_ready_back", 0, 64'(ir[0]), 64'd1);
        chk("bp_second", 0, 64'(odata[0]), 64'hB);
        step();

        // Flush while full with ctrl=11 and a simultaneous input beat.
        ordy[0] = 1'b0;
        set_in(0, 1'b1, 32'h11, 2'b11, 5'd3);
        step();
        set_in(0, 1'b1, 32'h12, 2'b11, 5'd4);
        step();
        set_in(0, 1'b1, 32'hC, 2'b11, 5'd5);
        fl[0] = 1'b1;
        step();
        set_in(0, 1'b0, '0, '0, '0);
        chk("fl_out_valid", 0, 64'(ov[0]), 64'd0);
        chk("fl_out_ctrl", 0, 64'(octrl[0]), 64'd0);
        chk("fl_occupancy", 0, 64'(occ[0]), 64'd0);
        ordy[0] = 1'b1;
        step();
        step();

        // Single-register stall with combinational in_ready.
        ordy[1] = 1'b0;
        set_in(1, 1'b1, 32'h5, 2'd1, 5'd5);
        step();
        set_in(1, 1'b0, '0, '0, '0);
        #1;
        chk("stall_in_ready", 1, 64'(ir[1]), 64'd0);
        ordy[1] = 1'b1;
        set_in(1, 1'b1, 32'h6, 2'd2, 5'd6);
        #1;
        chk("unstall_in_ready", 1, 64'(ir[1]), 64'd1);
        step();
        set_in(1, 1'b0, '0, '0, '0);
        chk("replace_data", 1, 64'(odata[1]), 64'h6);
        step();
        chk("drain_ctrl", 1, 64'(octrl[1]), 64'd0);
        chk("drain_data_held", 1, 64'(odata[1]), 64'h6);

        // Randomized traffic with varying backpressure, flushes and one mid-run reset.
        bias = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) bias = $urandom_range(1, 4);
            for (int k = 0; k < 2; k++) begin
                set_in(k, ($urandom_range(0, 3) != 0), $urandom, 2'($urandom_range(0, 3)),
                       5'($urandom_range(0, 31)));
                ordy[k] = ($urandom_range(0, 3) < bias);
                fl[k]   = ($urandom_range(0, 39) == 0);
            end
            step();
            if (c == 1500) do_reset();
        end

        for (int k = 0; k < 2; k++) begin
            set_in(k, 1'b0, '0, '0, '0);
            ordy[k] = 1'b1;
        end
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
